// File: rtl/parking_ctrl_n_if.sv
// Bus between the sensor debouncers (master) and the parking controller (slave).
// PARK_BCD_EN adds the two BCD display fields.
interface parking_ctrl_n_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  logic                 enter;
  logic                 exit;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 door_open;
  logic                 busy;
  logic                 reject;
  logic                 is_full;
  logic                 is_empty;
  logic [CNT_W-1:0]     free_count;
  logic [SLOT_W-1:0]    next_slot;
  logic [SLOT_W-1:0]    last_assigned;
  logic [NUM_SLOTS-1:0] occupancy;
`ifdef PARK_BCD_EN
  logic [7:0]           free_bcd;
  logic [7:0]           next_bcd;
`endif

  modport master (
    output enter, exit, exit_slot,
    input  door_open, busy, reject, is_full, is_empty, free_count,
    input  next_slot, last_assigned, occupancy
`ifdef PARK_BCD_EN
    , input free_bcd, next_bcd
`endif
  );

  modport slave (
    input  enter, exit, exit_slot,
    output door_open, busy, reject, is_full, is_empty, free_count,
    output next_slot, last_assigned, occupancy
`ifdef PARK_BCD_EN
    , output free_bcd, next_bcd
`endif
  );
endinterface

// File: rtl/parking_ctrl_n.sv
// N-slot parking controller: lowest-free-slot allocation, addressed exit, timed door pulse.
// Optional macro PARK_BCD_EN adds BCD free-count and next-slot display outputs.
module parking_ctrl_n #(
  parameter int NUM_SLOTS   = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  parking_ctrl_n_if.slave   bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int TMR_W  = $clog2(DOOR_CYCLES + 1);

  localparam logic [TMR_W-1:0]     DOOR_LOAD = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]     ALL_FREE  = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1'b1);
  localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1'b1);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = NUM_SLOTS'(1'b1);
  localparam logic [SLOT_W:0]      SLOT_LIM  = (SLOT_W + 1)'(NUM_SLOTS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DOOR = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [TMR_W-1:0]     timer_r, timer_s;
  logic [NUM_SLOTS-1:0] occ_r, occ_s;
  logic [CNT_W-1:0]     free_r, free_s;
  logic                 door_r, door_s;
  logic                 reject_r, reject_s;
  logic [SLOT_W-1:0]    last_r, last_s;

  logic [SLOT_W-1:0]    next_slot_s;
  logic                 found_s;
  logic                 slot_in_range_s;
  logic                 slot_occ_s;
  logic [NUM_SLOTS-1:0] entry_mask_s;
  logic [NUM_SLOTS-1:0] exit_mask_s;
  logic                 full_s;

`ifdef PARK_BCD_EN
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction
`endif

  // Priority encoder: lowest free slot, 0 when the lot is full.
  always_comb begin
    next_slot_s = {SLOT_W{1'b0}};
    found_s     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ_r[i] && !found_s) begin
        next_slot_s = SLOT_W'(i);
        found_s     = 1'b1;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Exit-slot validation and one-hot update masks.
  always_comb begin
    full_s          = (free_r == {CNT_W{1'b0}});
    slot_in_range_s = ({1'b0, bus.exit_slot} < SLOT_LIM);
    if (slot_in_range_s) begin
      slot_occ_s = occ_r[bus.exit_slot];
    end else begin
      slot_occ_s = 1'b0;
    end
    entry_mask_s = SLOT_ONE << next_slot_s;
    exit_mask_s  = SLOT_ONE << bus.exit_slot;
  end

  // Next-state logic: requests are only considered in IDLE, never queued during DOOR.
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    occ_s    = occ_r;
    free_s   = free_r;
    door_s   = door_r;
    reject_s = 1'b0;
    last_s   = last_r;
    case (state_r)
      IDLE: begin
        if (bus.enter && bus.exit) begin
          reject_s = 1'b1;
        end else if (bus.enter) begin
          if (full_s) begin
            reject_s = 1'b1;
          end else begin
            occ_s   = occ_r | entry_mask_s;
            last_s  = next_slot_s;
            free_s  = free_r - CNT_ONE;
            door_s  = 1'b1;
            timer_s = DOOR_LOAD;
            state_s = DOOR;
          end
        end else if (bus.exit) begin
          if (slot_occ_s) begin
            occ_s   = occ_r & ~exit_mask_s;
            free_s  = free_r + CNT_ONE;
            door_s  = 1'b1;
            timer_s = DOOR_LOAD;
            state_s = DOOR;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          reject_s = 1'b0;
        end
      end
      DOOR: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          door_s  = 1'b0;
          state_s = IDLE;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        door_s  = 1'b0;
        timer_s = {TMR_W{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      timer_r  <= {TMR_W{1'b0}};
      occ_r    <= {NUM_SLOTS{1'b0}};
      free_r   <= ALL_FREE;
      door_r   <= 1'b0;
      reject_r <= 1'b0;
      last_r   <= {SLOT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      occ_r    <= occ_s;
      free_r   <= free_s;
      door_r   <= door_s;
      reject_r <= reject_s;
      last_r   <= last_s;
    end
  end

  assign bus.door_open     = door_r;
  assign bus.busy          = (state_r == DOOR);
  assign bus.reject        = reject_r;
  assign bus.is_full       = full_s;
  assign bus.is_empty      = (free_r == ALL_FREE);
  assign bus.free_count    = free_r;
  assign bus.next_slot     = next_slot_s;
  assign bus.last_assigned = last_r;
  assign bus.occupancy     = occ_r;

`ifdef PARK_BCD_EN
  // Display is 1-based, so a full lot shows 00 rather than slot 1.
  assign bus.free_bcd = to_bcd(7'(free_r));
  assign bus.next_bcd = full_s ? 8'h00 : to_bcd(7'(next_slot_s) + 7'd1);
`endif

endmodule
